// File: rtl/iigs_io_pkg.sv
// Shared types and constants for the $C0xx I/O controller.
package iigs_io_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHAN  = 3'd1,
      ST_LOCAL = 3'd2,
      ST_DONE  = 3'd3,
      ST_HOLD  = 3'd4
   } io_state_e;

   localparam logic [7:0] UNMAPPED_RD = 8'h00;
   localparam logic [7:0] TIMEOUT_RD  = 8'hFF;
   localparam logic [7:0] ERR_MAX     = 8'd255;

   // Saturating increment used for the timeout error counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == ERR_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/iigs_io_ctrl_decode.sv
// Combinational address decode: channel window match with lowest-index
// priority, plus the local soft-switch register window.
module iigs_io_decode
   import iigs_io_pkg::*;
#(
   parameter int              NCH      = 4,
   parameter logic [NCH*8-1:0] CH_BASE = {8'hE0, 8'h70, 8'h33, 8'h10},
   parameter logic [NCH*8-1:0] CH_MASK = {8'hF0, 8'hFF, 8'hFE, 8'hFF},
   parameter logic [7:0]      LOC_BASE = 8'h20,
   parameter int              NLOC     = 32,
   parameter int              IDX_W    = 2,
   parameter int              LOC_W    = 5
) (
   input  logic [7:0]       addr,
   output logic             hit_valid,
   output logic [IDX_W-1:0] hit_idx,
   output logic             loc_hit,
   output logic [LOC_W-1:0] loc_idx
);

   logic [7:0] loc_off_s;
   logic       match_s;

   // Scan channels from highest to lowest so the lowest matching index wins.
   always_comb begin
      hit_valid = 1'b0;
      hit_idx   = '0;
      match_s   = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         match_s   = ((addr & CH_MASK[i*8 +: 8]) == CH_BASE[i*8 +: 8]);
         hit_valid = hit_valid | match_s;
         hit_idx   = match_s ? IDX_W'(i) : hit_idx;
      end
   end

   // Offset wraps modulo 256, so addresses below the base fall outside.
   assign loc_off_s = addr - LOC_BASE;
   assign loc_hit   = ({1'b0, loc_off_s} < 9'(NLOC));
   assign loc_idx   = loc_off_s[LOC_W-1:0];

endmodule

// File: rtl/iigs_io_ctrl.sv
// $C0xx I/O controller: decodes qualified accesses to peripheral channels
// or the local register file, runs the strobe/ack handshake with timeout,
// and returns read data with a one-cycle ready pulse.
module iigs_io_ctrl
   import iigs_io_pkg::*;
#(
   parameter int                     NCH      = 4,
   parameter int                     DATA_W   = 8,
   parameter logic [NCH*8-1:0]       CH_BASE  = {8'hE0, 8'h70, 8'h33, 8'h10},
   parameter logic [NCH*8-1:0]       CH_MASK  = {8'hF0, 8'hFF, 8'hFE, 8'hFF},
   parameter logic [7:0]             LOC_BASE = 8'h20,
   parameter int                     NLOC     = 32,
   parameter logic [NLOC*DATA_W-1:0] LOC_RST  = '0,
   parameter int                     TIMEOUT  = 16
) (
   input  logic                     clk_sys,
   input  logic                     reset_n,
   input  logic                     io_sel,
   input  logic [7:0]               io_addr,
   input  logic                     io_we,
   input  logic [DATA_W-1:0]        io_wdata,
   output logic [DATA_W-1:0]        io_rdata,
   output logic                     io_ready,
   output logic [NCH-1:0]           ch_strobe,
   output logic                     ch_rw,
   output logic [7:0]               ch_addr,
   output logic [DATA_W-1:0]        ch_wdata,
   input  logic [NCH*DATA_W-1:0]    ch_rdata,
   input  logic [NCH-1:0]           ch_ack,
   output logic [NLOC*DATA_W-1:0]   loc_regs,
   output logic [7:0]               err_count,
   output logic                     busy
);

   localparam int         IDX_W    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int         LOC_W    = (NLOC > 1) ? $clog2(NLOC) : 1;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic             hit_valid_s;
   logic [IDX_W-1:0] hit_idx_s;
   logic             loc_hit_s;
   logic [LOC_W-1:0] loc_idx_s;

   io_state_e                state_q, state_d;
   logic [IDX_W-1:0]         sel_idx_q, sel_idx_d;
   logic                     loc_hit_q, loc_hit_d;
   logic [LOC_W-1:0]         loc_idx_q, loc_idx_d;
   logic                     we_q, we_d;
   logic [DATA_W-1:0]        wdata_q, wdata_d;
   logic [7:0]               tmo_q, tmo_d;
   logic [DATA_W-1:0]        io_rdata_q, io_rdata_d;
   logic                     io_ready_q, io_ready_d;
   logic [NCH-1:0]           ch_strobe_q, ch_strobe_d;
   logic                     ch_rw_q, ch_rw_d;
   logic [7:0]               ch_addr_q, ch_addr_d;
   logic [DATA_W-1:0]        ch_wdata_q, ch_wdata_d;
   logic [NLOC*DATA_W-1:0]   loc_regs_q, loc_regs_d;
   logic [7:0]               err_count_q, err_count_d;
   logic                     busy_q, busy_d;

   iigs_io_decode #(
      .NCH      (NCH),
      .CH_BASE  (CH_BASE),
      .CH_MASK  (CH_MASK),
      .LOC_BASE (LOC_BASE),
      .NLOC     (NLOC),
      .IDX_W    (IDX_W),
      .LOC_W    (LOC_W)
   ) u_decode (
      .addr      (io_addr),
      .hit_valid (hit_valid_s),
      .hit_idx   (hit_idx_s),
      .loc_hit   (loc_hit_s),
      .loc_idx   (loc_idx_s)
   );

   // Next-state and next-output logic for the access FSM.
   // Unmapped accesses share the one-cycle LOCAL slot (with loc_hit_q low)
   // so that every non-channel access completes with the same latency.
   always_comb begin
      state_d     = state_q;
      sel_idx_d   = sel_idx_q;
      loc_hit_d   = loc_hit_q;
      loc_idx_d   = loc_idx_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      tmo_d       = tmo_q;
      io_rdata_d  = '0;
      io_ready_d  = 1'b0;
      ch_strobe_d = '0;
      ch_rw_d     = ch_rw_q;
      ch_addr_d   = ch_addr_q;
      ch_wdata_d  = ch_wdata_q;
      loc_regs_d  = loc_regs_q;
      err_count_d = err_count_q;

      case (state_q)
         ST_IDLE: begin
            if (io_sel) begin
               we_d    = io_we;
               wdata_d = io_wdata;
               if (hit_valid_s) begin
                  state_d     = ST_CHAN;
                  sel_idx_d   = hit_idx_s;
                  ch_strobe_d = NCH'(1'b1) << hit_idx_s;
                  ch_rw_d     = ~io_we;
                  ch_addr_d   = io_addr;
                  ch_wdata_d  = io_wdata;
                  tmo_d       = 8'd0;
               end else begin
                  state_d   = ST_LOCAL;
                  loc_hit_d = loc_hit_s;
                  loc_idx_d = loc_idx_s;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHAN: begin
            if (ch_ack[sel_idx_q]) begin
               state_d    = ST_DONE;
               io_ready_d = 1'b1;
               io_rdata_d = ch_rdata[sel_idx_q*DATA_W +: DATA_W];
            end else if (tmo_q == TMO_LAST) begin
               state_d     = ST_DONE;
               io_ready_d  = 1'b1;
               io_rdata_d  = DATA_W'(TIMEOUT_RD);
               err_count_d = sat_inc8(err_count_q);
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         ST_LOCAL: begin
            state_d    = ST_DONE;
            io_ready_d = 1'b1;
            if (loc_hit_q) begin
               if (we_q) begin
                  loc_regs_d[loc_idx_q*DATA_W +: DATA_W] = wdata_q;
                  io_rdata_d = '0;
               end else begin
                  io_rdata_d = loc_regs_q[loc_idx_q*DATA_W +: DATA_W];
               end
            end else begin
               io_rdata_d = DATA_W'(UNMAPPED_RD);
            end
         end
         ST_DONE: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!io_sel) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         sel_idx_q   <= '0;
         loc_hit_q   <= 1'b0;
         loc_idx_q   <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         tmo_q       <= 8'd0;
         io_rdata_q  <= '0;
         io_ready_q  <= 1'b0;
         ch_strobe_q <= '0;
         ch_rw_q     <= 1'b1;
         ch_addr_q   <= 8'h00;
         ch_wdata_q  <= '0;
         loc_regs_q  <= LOC_RST;
         err_count_q <= 8'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_idx_q   <= sel_idx_d;
         loc_hit_q   <= loc_hit_d;
         loc_idx_q   <= loc_idx_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         tmo_q       <= tmo_d;
         io_rdata_q  <= io_rdata_d;
         io_ready_q  <= io_ready_d;
         ch_strobe_q <= ch_strobe_d;
         ch_rw_q     <= ch_rw_d;
         ch_addr_q   <= ch_addr_d;
         ch_wdata_q  <= ch_wdata_d;
         loc_regs_q  <= loc_regs_d;
         err_count_q <= err_count_d;
         busy_q      <= busy_d;
      end
   end

   assign io_rdata  = io_rdata_q;
   assign io_ready  = io_ready_q;
   assign ch_strobe = ch_strobe_q;
   assign ch_rw     = ch_rw_q;
   assign ch_addr   = ch_addr_q;
   assign ch_wdata  = ch_wdata_q;
   assign loc_regs  = loc_regs_q;
   assign err_count = err_count_q;
   assign busy      = busy_q;

endmodule
